mux_sel_arbiter: RTL and testbench



---
 rtl/mux_sel_arbiter.sv | 111 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - two-source arbiter driving a 2:1 select mux with registered data copy
// Last-served priority, bounded hold time and a one-cycle gap on every ownership change.
module mux_sel_arbiter #(
  parameter int DW          = 1,
  parameter int HOLD_CYCLES = 4
) (
  input  logic          sysclk,
  input  logic          sys_rst,
  input  logic          req_0,
  input  logic          req_1,
  input  logic [DW-1:0] data_0,
  input  logic [DW-1:0] data_1,
  output logic          grant_0,
  output logic          grant_1,
  output logic          mux_sel,
  output logic          mux_en,
  output logic [DW-1:0] out_data,
  output logic          out_valid
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [3:0]    hold_cnt_q, hold_cnt_d;
  logic          grant_0_q, grant_0_d;
  logic          grant_1_q, grant_1_d;
  logic          mux_sel_q, mux_sel_d;
  logic          mux_en_q, mux_en_d;
  logic [DW-1:0] out_data_q, out_data_d;
  state_t        arb_pick;

  // Ties go to the source that was not served most recently.
  always_comb begin
    arb_pick = IDLE;
    if (req_0 && req_1) arb_pick = last_q ? OWN0 : OWN1;
    else if (req_0)     arb_pick = OWN0;
    else if (req_1)     arb_pick = OWN1;
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_cnt_d = 4'd0;
    case (state_q)
      IDLE, GAP: state_d = arb_pick;
      OWN0: begin
        if (!req_0 || (req_1 && hold_cnt_q == HOLD_LAST)) begin
          state_d = GAP;
          last_d  = 1'b0;
        end else if (req_1) begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      OWN1: begin
        if (!req_1 || (req_0 && hold_cnt_q == HOLD_LAST)) begin
          state_d = GAP;
          last_d  = 1'b1;
        end else if (req_0) begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    grant_0_d  = (state_d == OWN0);
    grant_1_d  = (state_d == OWN1);
    mux_en_d   = grant_0_d | grant_1_d;
    mux_sel_d  = mux_sel_q;
    out_data_d = out_data_q;
    if (grant_0_d) begin
      mux_sel_d  = 1'b0;
      out_data_d = data_0;
    end else if (grant_1_d) begin
      mux_sel_d  = 1'b1;
      out_data_d = data_1;
    end
  end

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      hold_cnt_q <= 4'd0;
      grant_0_q  <= 1'b0;
      grant_1_q  <= 1'b0;
      mux_sel_q  <= 1'b0;
      mux_en_q   <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      grant_0_q  <= grant_0_d;
      grant_1_q  <= grant_1_d;
      mux_sel_q  <= mux_sel_d;
      mux_en_q   <= mux_en_d;
      out_data_q <= out_data_d;
    end
  end

  assign grant_0   = grant_0_q;
  assign grant_1   = grant_1_q;
  assign mux_sel   = mux_sel_q;
  assign mux_en    = mux_en_q;
  assign out_valid = mux_en_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - directed vector bench for mux_sel_arbiter
module tb_mux_sel_arbiter;

  logic       sysclk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       req_0 = 1'b0, req_1 = 1'b0;
  logic [7:0] data_0 = 8'h00, data_1 = 8'h00;
  logic       grant_0, grant_1, mux_sel, mux_en, out_valid;
  logic [7:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  mux_sel_arbiter #(.DW(8), .HOLD_CYCLES(4)) dut (
    .sysclk(sysclk), .sys_rst(sys_rst),
    .req_0(req_0), .req_1(req_1), .data_0(data_0), .data_1(data_1),
    .grant_0(grant_0), .grant_1(grant_1), .mux_sel(mux_sel), .mux_en(mux_en),
    .out_data(out_data), .out_valid(out_valid)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic       r0, r1;
    logic [7:0] d0, d1;
    logic       g0, g1, sel;
    logic [7:0] od;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic g0, input logic g1,
                         input logic sel, input logic [7:0] od);
    chk({tag, ".grant_0"}, 32'(grant_0), 32'(g0));
    chk({tag, ".grant_1"}, 32'(grant_1), 32'(g1));
    chk({tag, ".mux_sel"}, 32'(mux_sel), 32'(sel));
    chk({tag, ".mux_en"}, 32'(mux_en), 32'(g0 | g1));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(g0 | g1));
    chk({tag, ".out_data"}, 32'(out_data), 32'(od));
  endtask

  task automatic tick();
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    sys_rst = 1'b1;
    req_0 = 1'b0; req_1 = 1'b0;
    #2 sys_rst = 1'b0;
  endtask

  always @(negedge sysclk) begin
    if (!sys_rst) begin
      chk("inv.one_hot", 32'(grant_0 & grant_1), 32'd0);
      chk("inv.mux_en", 32'(mux_en), 32'(grant_0 | grant_1));
      chk("inv.out_valid", 32'(out_valid), 32'(grant_0 | grant_1));
    end
  end

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1, 0, 8'h01, 8'h00, 1, 0, 0, 8'h01};
    vecs[1] = '{0, 0, 8'h02, 8'h00, 0, 0, 0, 8'h01};
    vecs[2] = '{0, 0, 8'h02, 8'h00, 0, 0, 0, 8'h01};
    vecs[3] = '{1, 1, 8'h11, 8'h22, 0, 1, 1, 8'h22};
    vecs[4] = '{1, 1, 8'h11, 8'h5A, 0, 1, 1, 8'h5A};
    vecs[5] = '{1, 1, 8'h11, 8'hA5, 0, 1, 1, 8'hA5};
    vecs[6] = '{1, 0, 8'h11, 8'hFF, 0, 0, 1, 8'hA5};
    vecs[7] = '{1, 0, 8'h33, 8'hFF, 1, 0, 0, 8'h33};
    vecs[8] = '{0, 0, 8'h44, 8'hFF, 0, 0, 0, 8'h33};
    vecs[9] = '{0, 0, 8'h44, 8'hFF, 0, 0, 0, 8'h33};

    // Reset values while reset is held.
    #1 chk_out("reset", 0, 0, 0, 8'h00);
    do_reset();

    @(negedge sysclk);
    for (int i = 0; i < 10; i++) begin
      req_0 = vecs[i].r0; req_1 = vecs[i].r1;
      data_0 = vecs[i].d0; data_1 = vecs[i].d1;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].sel, vecs[i].od);
    end

    // Simultaneous first request after reset: source 0 first, then 1 after a gap.
    do_reset();
    @(negedge sysclk);
    req_0 = 1; req_1 = 1; data_0 = 8'h10; data_1 = 8'h20;
    tick();
    chk_out("tie.first", 1, 0, 0, 8'h10);
    req_0 = 0;
    tick();
    chk_out("tie.gap", 0, 0, 0, 8'h10);
    tick();
    chk_out("tie.second", 0, 1, 1, 8'h20);

    // Two continuous requesters: 4 owned cycles then one gap, alternating.
    do_reset();
    @(negedge sysclk);
    req_0 = 1; req_1 = 1; data_0 = 8'h0A; data_1 = 8'h0B;
    begin
      int run;
      int ph;
      logic eg0, eg1, esel;
      run = 0;
      for (int k = 0; k < 30; k++) begin
        tick();
        ph   = k % 10;
        eg0  = (ph < 4);
        eg1  = (ph >= 5 && ph < 9);
        esel = (ph >= 5);
        chk_out($sformatf("pre%0d", k), eg0, eg1, esel, esel ? 8'h0B : 8'h0A);
        run = (grant_0 | grant_1) ? run + 1 : 0;
        chk($sformatf("pre%0d.run_le4", k), 32'(run > 4), 32'd0);
      end
    end

    // Asynchronous reset mid-grant, then re-grant with req_1 still high.
    do_reset();
    @(negedge sysclk);
    req_1 = 1; data_1 = 8'h3C;
    tick();
    chk_out("rst.own1", 0, 1, 1, 8'h3C);
    sys_rst = 1'b1;
    #1 chk_out("rst.async", 0, 0, 0, 8'h00);
    #1 sys_rst = 1'b0;
    @(posedge sysclk);
    @(posedge sysclk);
    #1 chk_out("rst.regrant", 0, 1, 1, 8'h3C);

    req_0 = 0; req_1 = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
